serial_add_ctrl: RTL and testbench

- Bit-serial adder controller: accepts two WIDTH-bit operands over a start/ready handshake, then adds them one bit per clock, LSB first.
- Datapath is the team's existing half_adder cell: two instances form one full adder (port order a, b, carry, sum), plus a registered carry.
- Sequences the full adder over WIDTH cycles and presents the registered sum/carry-out with a one-cycle done pulse.
- Intended for area-constrained paths where a parallel WIDTH-bit adder is not justified.

---
 rtl/serial_add_ctrl.sv | 119 +++++++++++
 tb/tb_serial_add_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial WIDTH-bit adder built from two half_adder cells
// Optional subtract mode (sub port, a - b) is enabled by defining SERIAL_ADD_SUB_EN.

module half_adder (
  input  logic a,
  input  logic b,
  output logic carry,
  output logic sum
);
  assign carry = a & b;
  assign sum   = a ^ b;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] op_a_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             c1, c2, s1, s2;
  logic [WIDTH-1:0] load_b;
  logic             carry_init;

`ifdef SERIAL_ADD_SUB_EN
  assign load_b     = sub ? ~b : b;
  assign carry_init = sub;
`else
  assign load_b     = b;
  assign carry_init = 1'b0;
`endif

  half_adder ha0 (.a(op_a[0]), .b(op_b[0]), .carry(c1), .sum(s1));
  half_adder ha1 (.a(s1),      .b(carry),   .carry(c2), .sum(s2));

  // op_a doubles as the result register: each sum bit enters at the MSB as
  // the consumed operand bit leaves at the LSB, so after WIDTH shifts it holds the result.
  generate
    if (WIDTH == 1) begin : g_narrow
      assign op_a_next = s2;
    end else begin : g_wide
      assign op_a_next = {s2, op_a[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      op_a  <= '0;
      op_b  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= load_b;
            carry <= carry_init;
            cnt   <= '0;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          op_a  <= op_a_next;
          op_b  <= op_b >> 1;
          carry <= c1 | c2;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= op_a_next;
            cout  <= c1 | c2;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl (WIDTH=8)
// Subtract tests are compiled in only when SERIAL_ADD_SUB_EN is defined.

module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       sub = 1'b0;
  logic       ready, busy, done, cout;
  logic [7:0] sum;

  int total = 0;
  int bad = 0;
  logic [7:0] last_sum = '0;
  logic       last_cout = 1'b0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h want=00", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout); end
    last_sum = '0;
    last_cout = 1'b0;
  endtask

  task automatic test_op(input logic [7:0] xa, input logic [7:0] xb, input logic xsub);
    logic [8:0] exp;
    int n;
    int lat;
    bit hold_ok;
    exp = xsub ? ({1'b0, xa} + {1'b0, ~xb} + 9'd1) : ({1'b0, xa} + {1'b0, xb});
    n = 0;
    while (!ready && n < 30) begin tick(); n++; end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL op_wait_ready got=%b want=1", ready); end
    a = xa; b = xb; sub = xsub; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    lat = 0;
    hold_ok = 1'b1;
    while (done !== 1'b1 && lat < 20) begin
      if (sum !== last_sum || cout !== last_cout) hold_ok = 1'b0;
      tick();
      lat++;
    end
    total++; if (lat != 8) begin bad++; $display("FAIL op_latency a=%h b=%h got=%0d want=8", xa, xb, lat); end
    total++; if (!hold_ok) begin bad++; $display("FAIL op_hold got=changed want=held sum=%h", last_sum); end
    total++; if (sum !== exp[7:0]) begin bad++; $display("FAIL op_sum a=%h b=%h sub=%b got=%h want=%h", xa, xb, xsub, sum, exp[7:0]); end
    total++; if (cout !== exp[8]) begin bad++; $display("FAIL op_cout a=%h b=%h sub=%b got=%b want=%b", xa, xb, xsub, cout, exp[8]); end
    tick();
    total++; if (ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL op_after ready=%b done=%b want ready=1 done=0", ready, done); end
    total++; if (sum !== exp[7:0]) begin bad++; $display("FAIL op_sum_held got=%h want=%h", sum, exp[7:0]); end
    last_sum = exp[7:0];
    last_cout = exp[8];
  endtask

  task automatic test_directed();
    test_op(8'h3C, 8'h5A, 1'b0);
    test_op(8'hFF, 8'h01, 1'b0);
    test_op(8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_ignored_start();
    int pulses;
    logic [7:0] s_at;
    a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign_busy got=%b want=1", busy); end
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    s_at = '0;
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1) begin pulses++; s_at = sum; end
      tick();
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL ign_pulses got=%0d want=1", pulses); end
    total++; if (s_at !== 8'h30 || cout !== 1'b0) begin bad++; $display("FAIL ign_result got=%h/%b want=30/0", s_at, cout); end
    total++; if (busy !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL ign_idle busy=%b ready=%b want 0/1", busy, ready); end
    last_sum = 8'h30;
    last_cout = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    test_op(8'h77, 8'h11, 1'b0);
    a = 8'h12; b = 8'h34; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_ctrl r=%b b=%b d=%b want 1/0/0", ready, busy, done); end
    total++; if (sum !== 8'h00 || cout !== 1'b0) begin bad++; $display("FAIL mid_result got=%h/%b want=00/0", sum, cout); end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", pulses); end
    last_sum = '0;
    last_cout = 1'b0;
  endtask

  task automatic test_back_to_back();
    int pulses;
    int prev_t;
    bit stable;
    int n;
    a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
    pulses = 0;
    prev_t = -1;
    stable = 1'b1;
    for (int t = 0; t < 45; t++) begin
      tick();
      if (done === 1'b1) begin
        total++; if (sum !== 8'h03 || cout !== 1'b0) begin bad++; $display("FAIL b2b_sum t=%0d got=%h/%b want=03/0", t, sum, cout); end
        if (prev_t >= 0) begin
          total++; if (t - prev_t != 10) begin bad++; $display("FAIL b2b_period got=%0d want=10", t - prev_t); end
        end
        prev_t = t;
        pulses++;
      end else if (pulses > 0 && sum !== 8'h03) begin
        stable = 1'b0;
      end
    end
    start = 1'b0;
    total++; if (pulses < 4) begin bad++; $display("FAIL b2b_pulses got=%0d want>=4", pulses); end
    total++; if (!stable) begin bad++; $display("FAIL b2b_stable got=changed want=03"); end
    n = 0;
    while (!ready && n < 30) begin tick(); n++; end
    tick();
    last_sum = 8'h03;
    last_cout = 1'b0;
  endtask

  task automatic test_random();
    logic xs;
    for (int i = 0; i < 20; i++) begin
`ifdef SERIAL_ADD_SUB_EN
      xs = 1'($urandom);
`else
      xs = 1'b0;
`endif
      test_op(8'($urandom), 8'($urandom), xs);
    end
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    test_op(8'h05, 8'h07, 1'b1);
    test_op(8'h07, 8'h05, 1'b1);
    test_op(8'h3C, 8'h5A, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
